// File: rtl/imm_packer.sv
// Purpose: packs a 32-bit constant (LI) or byte branch offset (BRANCH) into MIPS instruction beats plus extender code.
// Latency: one cycle; an accept at edge N presents beat 1 from edge N. LI values that need two beats add one more beat (lui, then ori).
// Backpressure: all out_* fields hold while out_valid & !out_ready. in_ready is high only when idle or when the final beat is being consumed.
//
// Ports:
//   clk, reset                - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         - request handshake; in_mode 0=LI, 1=BRANCH
//   in_value, in_rs, in_rt    - constant or byte offset, register fields
//   out_valid/out_ready       - beat handshake
//   out_instr, out_imm        - encoded instruction word and its immediate field
//   out_eop                   - extender code that rebuilds the beat: 0 sext, 1 zext, 2 upper, 3 sext<<2
//   out_last, out_err         - final beat of the request, request not encodable
//   err_cnt                   - saturating count of errored requests
module imm_packer #(
    parameter logic [5:0] ADDIU_OP = 6'h09,
    parameter logic [5:0] ORI_OP   = 6'h0d,
    parameter logic [5:0] LUI_OP   = 6'h0f,
    parameter logic [5:0] BEQ_OP   = 6'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

    state_t      state;
    logic [31:0] pend_instr;
    logic [15:0] pend_imm;

    logic accept;
    logic consume;

    // Fields of the first beat (and the optional second beat), decoded from the live inputs.
    logic [31:0] b1_instr;
    logic [15:0] b1_imm;
    logic [1:0]  b1_eop;
    logic        b1_last;
    logic        b1_err;
    logic [31:0] b2_instr;
    logic [15:0] b2_imm;

    logic fits_sext16;
    logic br_legal;

    assign in_ready = (state == IDLE) | (out_valid & out_last & out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    // Value reproducible by sign-extending its low half: bits 31..15 all equal.
    assign fits_sext16 = (&in_value[31:15]) | ~(|in_value[31:15]);
    // Word-aligned and within the 18-bit signed byte range that a 16-bit word offset covers.
    assign br_legal    = (in_value[1:0] == 2'b00) &&
                         ((&in_value[31:17]) | ~(|in_value[31:17]));

    always_comb begin
        b1_instr = '0;
        b1_imm   = '0;
        b1_eop   = 2'd0;
        b1_last  = 1'b1;
        b1_err   = 1'b0;
        b2_instr = '0;
        b2_imm   = '0;
        if (!in_mode) begin
            if (fits_sext16) begin
                b1_imm   = in_value[15:0];
                b1_instr = {ADDIU_OP, 5'd0, in_rt, in_value[15:0]};
                b1_eop   = 2'd0;
            end else if (in_value[31:16] == 16'h0000) begin
                b1_imm   = in_value[15:0];
                b1_instr = {ORI_OP, 5'd0, in_rt, in_value[15:0]};
                b1_eop   = 2'd1;
            end else if (in_value[15:0] == 16'h0000) begin
                b1_imm   = in_value[31:16];
                b1_instr = {LUI_OP, 5'd0, in_rt, in_value[31:16]};
                b1_eop   = 2'd2;
            end else begin
                // lui loads the upper half, then ori merges the lower half into the same register.
                b1_imm   = in_value[31:16];
                b1_instr = {LUI_OP, 5'd0, in_rt, in_value[31:16]};
                b1_eop   = 2'd2;
                b1_last  = 1'b0;
                b2_imm   = in_value[15:0];
                b2_instr = {ORI_OP, in_rt, in_rt, in_value[15:0]};
            end
        end else begin
            b1_eop = 2'd3;
            if (br_legal) begin
                b1_imm   = in_value[17:2];
                b1_instr = {BEQ_OP, in_rs, in_rt, in_value[17:2]};
            end else begin
                b1_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_imm    <= '0;
            out_eop    <= 2'd0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            err_cnt    <= '0;
            pend_instr <= '0;
            pend_imm   <= '0;
        end else if (accept) begin
            // Also covers back-to-back: the previous last beat is consumed on this same edge.
            state      <= BEAT1;
            out_valid  <= 1'b1;
            out_instr  <= b1_instr;
            out_imm    <= b1_imm;
            out_eop    <= b1_eop;
            out_last   <= b1_last;
            out_err    <= b1_err;
            pend_instr <= b2_instr;
            pend_imm   <= b2_imm;
            if (b1_err && err_cnt != 8'hff) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (consume) begin
            if (state == BEAT1 && !out_last) begin
                state     <= BEAT2;
                out_instr <= pend_instr;
                out_imm   <= pend_imm;
                out_eop   <= 2'd1;
                out_last  <= 1'b1;
                out_err   <= 1'b0;
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// Purpose: directed self-checking bench for imm_packer.
// Latency: checks that beat 1 is visible in the cycle after accept and that back-to-back requests leave no bubble.
// Backpressure: stalls out_ready to check that held beats stay stable; also checks that reset drops a request mid-flight.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_value;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_value  (in_value),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_imm   (out_imm),
        .out_eop   (out_eop),
        .out_last  (out_last),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request from a negedge and hold it until the accepting posedge.
    task automatic do_req(input logic mode, input logic [31:0] value,
                          input logic [4:0] rs, input logic [4:0] rt);
        bit done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_value = value;
        in_rs    = rs;
        in_rt    = rt;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    // Wait for a beat, compare every field, then let it be consumed at the next posedge.
    task automatic expect_beat(input string tag, input logic [31:0] instr, input logic [15:0] imm,
                               input logic [1:0] eop, input logic last, input logic err);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk({tag, "_valid"}, {31'd0, seen}, 32'd1);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_imm"},   {16'd0, out_imm}, {16'd0, imm});
        chk({tag, "_eop"},   {30'd0, out_eop}, {30'd0, eop});
        chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
        chk({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_beat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_value  = '0;
        in_rs     = '0;
        in_rt     = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_imm",   {16'd0, out_imm}, 32'd0);
        chk("rst_out_eop",   {30'd0, out_eop}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last}, 32'd0);
        chk("rst_out_err",   {31'd0, out_err}, 32'd0);
        chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

        // LI single-beat cases: addiu, ori, lui
        do_req(1'b0, 32'hFFFF8000, 5'd0, 5'd8);
        expect_beat("li_addiu", 32'h24088000, 16'h8000, 2'd0, 1'b1, 1'b0);
        do_req(1'b0, 32'h0000ABCD, 5'd0, 5'd9);
        expect_beat("li_ori", 32'h3409ABCD, 16'hABCD, 2'd1, 1'b1, 1'b0);
        do_req(1'b0, 32'h12340000, 5'd0, 5'd9);
        expect_beat("li_lui", 32'h3C091234, 16'h1234, 2'd2, 1'b1, 1'b0);
        do_req(1'b0, 32'h00007FFF, 5'd0, 5'd1);
        expect_beat("li_addiu_pos", 32'h24017FFF, 16'h7FFF, 2'd0, 1'b1, 1'b0);

        // LI two-beat with out_ready stalled for 3 cycles
        out_ready = 1'b0;
        do_req(1'b0, 32'h12345678, 5'd0, 5'd10);
        in_value = 32'hDEADBEEF;
        in_rt    = 5'd31;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_instr", out_instr, 32'h3C0A1234);
            chk("stall_last",  {31'd0, out_last}, 32'd0);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_beat("li_2nd", 32'h354A5678, 16'h5678, 2'd1, 1'b1, 1'b0);

        // BRANCH legal and illegal
        do_req(1'b1, 32'hFFFFFFFC, 5'd1, 5'd2);
        expect_beat("br_neg4", 32'h1022FFFF, 16'hFFFF, 2'd3, 1'b1, 1'b0);
        chk("br_legal_cnt", {24'd0, err_cnt}, 32'd0);
        do_req(1'b1, 32'h00020000, 5'd1, 5'd2);
        chk("br_range_cnt", {24'd0, err_cnt}, 32'd1);
        expect_beat("br_range", 32'h0, 16'h0, 2'd3, 1'b1, 1'b1);
        do_req(1'b1, 32'h00000006, 5'd3, 5'd4);
        chk("br_align_cnt", {24'd0, err_cnt}, 32'd2);
        expect_beat("br_align", 32'h0, 16'h0, 2'd3, 1'b1, 1'b1);
        do_req(1'b1, 32'hFFFE0000, 5'd5, 5'd6);
        expect_beat("br_min", 32'h10A68000, 16'h8000, 2'd3, 1'b1, 1'b0);

        // Back-to-back single-beat LI requests: one beat per cycle
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_value = 32'h00000005; in_rt = 5'd3;
        @(negedge clk);
        chk("b2b_1_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_1_instr", out_instr, 32'h24030005);
        chk("b2b_1_ready", {31'd0, in_ready}, 32'd1);
        in_value = 32'h0000FFFF; in_rt = 5'd4;
        @(negedge clk);
        chk("b2b_2_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_2_instr", out_instr, 32'h3404FFFF);
        in_value = 32'h80000000; in_rt = 5'd5;
        @(negedge clk);
        chk("b2b_3_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_3_instr", out_instr, 32'h3C058000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // err_cnt saturation: stream illegal branches back-to-back
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_value = 32'h00000006;
        repeat (260) @(negedge clk);
        in_valid = 1'b0;
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'h000000ff);
        @(negedge clk);
        @(negedge clk);

        // Reset during beat 1 of a two-beat LI
        out_ready = 1'b0;
        do_req(1'b0, 32'h12345678, 5'd0, 5'd10);
        @(negedge clk);
        chk("mid_beat1_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_beat1_last",  {31'd0, out_last}, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_cnt",   {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        saw_beat = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw_beat = 1;
        end
        chk("mid_rst_no_ori", {31'd0, saw_beat}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
